// File: rtl/ts_eltwise_mac_pkg.sv
// Shared encodings and default sizing for the element-wise MAC block.
package ts_pkg;

  localparam int TS_LANES = 8;
  localparam int TS_DW    = 8;
  localparam int TS_ACC_W = 20;
  localparam int TS_LAT   = 2;

  typedef enum logic [1:0] {
    TS_OP_MUL = 2'd0,
    TS_OP_MAC = 2'd1,
    TS_OP_CLR = 2'd2,
    TS_OP_RSV = 2'd3
  } ts_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_eltwise_mac_lane.sv
// One lane: extend, multiply, accumulate with overflow detection.
// With TS_ACC_SAT_EN defined, MAC overflow clamps instead of wrapping.
module ts_lane_mac
  import ts_pkg::*;
#(
  parameter int DW    = TS_DW,
  parameter int ACC_W = TS_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  input  ts_op_e           op_i,
  input  logic             sgn_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             sat_o
);

  logic signed [DW:0]      a_x, b_x;
  logic signed [2*DW+1:0]  prod_full;
  logic [2*DW-1:0]         prod;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W:0]          sum;
  logic [ACC_W-1:0]        wrapped;
  logic                    ovf_u, ovf_s, ovf;
  logic [ACC_W-1:0]        mac_val;
  logic [ACC_W-1:0]        acc_q;
  logic                    sat_q;

  function automatic logic [ACC_W-1:0] extend(input logic [2*DW-1:0] p, input logic s);
    logic [ACC_W-1:0] r;
    r = '0;
    r[2*DW-1:0] = p;
    for (int i = 2*DW; i < ACC_W; i++) r[i] = s & p[2*DW-1];
    return r;
  endfunction

`ifdef TS_ACC_SAT_EN
  // Signed overflow only occurs when both addends share a sign, so the
  // product sign selects the clamp direction.
  function automatic logic [ACC_W-1:0] sat_clamp(input logic neg, input logic s);
    logic [ACC_W-1:0] r;
    if (!s)      r = '1;
    else if (neg) r = {1'b1, {(ACC_W-1){1'b0}}};
    else          r = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction
`endif

  assign a_x       = sgn_i ? $signed({a_i[DW-1], a_i}) : $signed({1'b0, a_i});
  assign b_x       = sgn_i ? $signed({b_i[DW-1], b_i}) : $signed({1'b0, b_i});
  assign prod_full = a_x * b_x;
  assign prod      = prod_full[2*DW-1:0];
  assign prod_ext  = extend(prod, sgn_i);

  assign sum     = {1'b0, acc_q} + {1'b0, prod_ext};
  assign wrapped = sum[ACC_W-1:0];
  assign ovf_u   = sum[ACC_W];
  assign ovf_s   = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (wrapped[ACC_W-1] != acc_q[ACC_W-1]);
  assign ovf     = sgn_i ? ovf_s : ovf_u;

`ifdef TS_ACC_SAT_EN
  assign mac_val = ovf ? sat_clamp(prod_ext[ACC_W-1], sgn_i) : wrapped;
`else
  assign mac_val = wrapped;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (upd_i) begin
      case (op_i)
        TS_OP_MAC: begin
          acc_q <= mac_val;
          if (ovf) sat_q <= 1'b1;
        end
        TS_OP_CLR: begin
          acc_q <= '0;
          sat_q <= 1'b0;
        end
        default: acc_q <= prod_ext;
      endcase
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/ts_eltwise_mac.sv
// Element-wise multiply / multiply-accumulate with ap_ctrl_chain handshake.
// Optional build macro TS_ACC_SAT_EN enables saturating MAC in every lane.
module ts_eltwise_mac
  import ts_pkg::*;
#(
  parameter int LANES = TS_LANES,
  parameter int DW    = TS_DW,
  parameter int ACC_W = TS_ACC_W,
  parameter int LAT   = TS_LAT
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   ap_ce,
  input  logic                   ap_start,
  input  logic                   ap_continue,
  output logic                   ap_idle,
  output logic                   ap_ready,
  output logic                   ap_done,
  input  logic [LANES*DW-1:0]    a_data,
  input  logic [LANES*DW-1:0]    b_data,
  input  logic [1:0]             op,
  input  logic                   sgn,
  output logic [LANES*ACC_W-1:0] c_data_out,
  output logic                   c_data_available_port,
  output logic [LANES-1:0]       sat_flags
);

  localparam int CNT_W = 4;

  ts_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 avail_q;
  logic [LANES*DW-1:0]  a_q, b_q;
  ts_op_e               op_q;
  logic                 sgn_q;
  logic                 accept;
  logic                 upd;

  assign accept = ap_ce && (state_q == ST_IDLE) && ap_start;
  assign upd    = ap_ce && (state_q == ST_BUSY) && (cnt_q == '0);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      avail_q <= 1'b0;
    end else if (ap_ce) begin
      case (state_q)
        ST_IDLE: if (ap_start) begin
          state_q <= ST_BUSY;
          cnt_q   <= CNT_W'(LAT - 1);
        end
        ST_BUSY: if (cnt_q == '0) begin
          state_q <= ST_DONE;
          avail_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        ST_DONE: if (ap_continue) begin
          state_q <= ST_IDLE;
          avail_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operands are captured only on the accepting edge and held through BUSY.
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      a_q   <= a_data;
      b_q   <= b_data;
      op_q  <= ts_op_e'(op);
      sgn_q <= sgn;
    end
  end

  assign ap_idle               = (state_q == ST_IDLE);
  assign ap_ready              = (state_q == ST_IDLE);
  assign ap_done               = (state_q == ST_DONE);
  assign c_data_available_port = avail_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ts_lane_mac #(
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk_i (ap_clk),
      .rst_i (ap_rst),
      .upd_i (upd),
      .a_i   (a_q[i*DW +: DW]),
      .b_i   (b_q[i*DW +: DW]),
      .op_i  (op_q),
      .sgn_i (sgn_q),
      .acc_o (c_data_out[i*ACC_W +: ACC_W]),
      .sat_o (sat_flags[i])
    );
  end

endmodule

// File: tb/tb_ts_eltwise_mac.sv
// Directed bench for ts_eltwise_mac; honours TS_ACC_SAT_EN for overflow expectations.
module tb_ts_eltwise_mac;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int ACC_W = 20;
  localparam int LAT   = 2;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst, ap_ce, ap_start, ap_continue;
  logic                   ap_idle, ap_ready, ap_done;
  logic [LANES*DW-1:0]    a_data, b_data;
  logic [1:0]             op;
  logic                   sgn;
  logic [LANES*ACC_W-1:0] c_data_out;
  logic                   c_data_available_port;
  logic [LANES-1:0]       sat_flags;

  int errors = 0;
  int checks = 0;

  ts_eltwise_mac #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .LAT(LAT)) dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .ap_ce                 (ap_ce),
    .ap_start              (ap_start),
    .ap_continue           (ap_continue),
    .ap_idle               (ap_idle),
    .ap_ready              (ap_ready),
    .ap_done               (ap_done),
    .a_data                (a_data),
    .b_data                (b_data),
    .op                    (op),
    .sgn                   (sgn),
    .c_data_out            (c_data_out),
    .c_data_available_port (c_data_available_port),
    .sat_flags             (sat_flags)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Issues one transaction, returns cycles from accept edge to ap_done (-1 on timeout).
  task automatic run_txn(input logic [1:0] o, input logic s, input logic [63:0] a,
                         input logic [63:0] b, output int lat);
    op = o; sgn = s; a_data = a; b_data = b;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    lat = 0;
    while (ap_done !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    if (lat >= 50) lat = -1;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_ce = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    a_data = '0; b_data = '0; op = 2'd0; sgn = 1'b0;
    tick(); tick();
    ap_rst = 1'b0;
    checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b1 || ap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: idle=%b ready=%b done=%b required 1 1 0", ap_idle, ap_ready, ap_done);
    end
    checks++;
    if (c_data_out !== '0 || c_data_available_port !== 1'b0 || sat_flags !== '0) begin
      errors++;
      $display("FAIL reset_data: c=%h avail=%b sat=%b required 0 0 0", c_data_out, c_data_available_port, sat_flags);
    end
  endtask

  task automatic test_mul_unsigned();
    int lat;
    logic [LANES*ACC_W-1:0] exp;
    run_txn(2'd0, 1'b0, 64'h8000_0000_0000_02FF, 64'h0200_0000_0000_03FF, lat);
    exp = '0;
    exp[0*ACC_W +: ACC_W] = 20'h0FE01;
    exp[1*ACC_W +: ACC_W] = 20'h00006;
    exp[7*ACC_W +: ACC_W] = 20'h00100;
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL mul_u_latency: got %0d cycles required %0d", lat, LAT);
    end
    checks++;
    if (c_data_out !== exp) begin
      errors++;
      $display("FAIL mul_u_data: got %h required %h", c_data_out, exp);
    end
    checks++;
    if (c_data_available_port !== 1'b0 || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL mul_u_idle: avail=%b idle=%b required 0 1", c_data_available_port, ap_idle);
    end
  endtask

  task automatic test_mul_signed();
    int lat;
    logic [LANES*ACC_W-1:0] exp;
    run_txn(2'd0, 1'b1, 64'h0000_0000_0002_FF80, 64'h0000_0000_00FE_FF7F, lat);
    exp = '0;
    exp[0*ACC_W +: ACC_W] = 20'hFC080;
    exp[1*ACC_W +: ACC_W] = 20'h00001;
    exp[2*ACC_W +: ACC_W] = 20'hFFFFC;
    checks++;
    if (c_data_out !== exp) begin
      errors++;
      $display("FAIL mul_s_data: got %h required %h", c_data_out, exp);
    end
  endtask

  task automatic test_mac_chain();
    int lat;
    logic [LANES*ACC_W-1:0] exp;
    run_txn(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    checks++;
    if (c_data_out !== '0 || sat_flags !== '0) begin
      errors++;
      $display("FAIL clr: c=%h sat=%b required 0 0", c_data_out, sat_flags);
    end
    run_txn(2'd1, 1'b0, {8{8'h10}}, {8{8'h10}}, lat);
    exp = {8{20'h00100}};
    checks++;
    if (c_data_out !== exp) begin
      errors++;
      $display("FAIL mac_first: got %h required %h", c_data_out, exp);
    end
    run_txn(2'd1, 1'b0, {8{8'h10}}, {8{8'h10}}, lat);
    run_txn(2'd1, 1'b0, {8{8'h10}}, {8{8'h10}}, lat);
    exp = {8{20'h00300}};
    checks++;
    if (c_data_out !== exp || sat_flags !== '0) begin
      errors++;
      $display("FAIL mac_chain: got %h sat=%b required %h sat=0", c_data_out, sat_flags, exp);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [ACC_W-1:0] exp17;
    run_txn(2'd2, 1'b0, 64'h0, 64'h0, lat);
    for (int i = 0; i < 16; i++) run_txn(2'd1, 1'b0, 64'hFF, 64'hFF, lat);
    checks++;
    if (c_data_out[0 +: ACC_W] !== 20'hFE010 || sat_flags !== 8'h00) begin
      errors++;
      $display("FAIL mac16: lane0=%h sat=%b required fe010 00000000", c_data_out[0 +: ACC_W], sat_flags);
    end
    run_txn(2'd1, 1'b0, 64'hFF, 64'hFF, lat);
`ifdef TS_ACC_SAT_EN
    exp17 = 20'hFFFFF;
`else
    exp17 = 20'h0DE11;
`endif
    checks++;
    if (c_data_out[0 +: ACC_W] !== exp17 || sat_flags !== 8'h01) begin
      errors++;
      $display("FAIL mac17_ovf: lane0=%h sat=%b required %h 00000001", c_data_out[0 +: ACC_W], sat_flags, exp17);
    end
    // Reserved op behaves as MUL and leaves the sticky flag alone.
    run_txn(2'd3, 1'b0, 64'h03, 64'h05, lat);
    checks++;
    if (c_data_out[0 +: ACC_W] !== 20'h0000F || sat_flags !== 8'h01) begin
      errors++;
      $display("FAIL op3_mul: lane0=%h sat=%b required 0000f 00000001", c_data_out[0 +: ACC_W], sat_flags);
    end
    run_txn(2'd2, 1'b0, 64'h0, 64'h0, lat);
    checks++;
    if (sat_flags !== 8'h00 || c_data_out !== '0) begin
      errors++;
      $display("FAIL clr_sat: sat=%b c=%h required 0 0", sat_flags, c_data_out);
    end
  endtask

  task automatic test_handshake();
    int n;
    op = 2'd0; sgn = 1'b0; a_data = 64'h11; b_data = 64'h02;
    ap_start = 1'b1;
    tick();
    // Start held in BUSY with new operands must not relatch.
    a_data = 64'h77; b_data = 64'h77;
    n = 0;
    while (ap_done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL hs_latency: got %0d required %0d", n, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      ap_start = i[0];
      ap_ce    = i[1] | i[0];
      a_data   = {$urandom, $urandom};
      tick();
      checks++;
      if (ap_done !== 1'b1 || ap_idle !== 1'b0 || c_data_available_port !== 1'b1 ||
          c_data_out[0 +: ACC_W] !== 20'h00022) begin
        errors++;
        $display("FAIL hs_hold[%0d]: done=%b idle=%b avail=%b lane0=%h required 1 0 1 00022",
                 i, ap_done, ap_idle, c_data_available_port, c_data_out[0 +: ACC_W]);
      end
    end
    ap_ce = 1'b1; ap_start = 1'b0; ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || c_data_available_port !== 1'b0 ||
        c_data_out[0 +: ACC_W] !== 20'h00022) begin
      errors++;
      $display("FAIL hs_release: idle=%b done=%b avail=%b lane0=%h required 1 0 0 00022",
               ap_idle, ap_done, c_data_available_port, c_data_out[0 +: ACC_W]);
    end
  endtask

  task automatic test_ce_stall();
    int n;
    op = 2'd0; sgn = 1'b0; a_data = 64'h03; b_data = 64'h03;
    ap_ce = 1'b0; ap_start = 1'b1;
    tick();
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL ce_idle_block: idle=%b required 1", ap_idle);
    end
    ap_ce = 1'b1;
    tick();
    ap_start = 1'b0;
    ap_ce = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n++;
      if (ap_done === 1'b1) break;
    end
    ap_ce = 1'b1;
    while (ap_done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n !== LAT + 3) begin
      errors++;
      $display("FAIL ce_stall_latency: got %0d required %0d", n, LAT + 3);
    end
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    checks++;
    if (c_data_out[0 +: ACC_W] !== 20'h00009) begin
      errors++;
      $display("FAIL ce_stall_data: lane0=%h required 00009", c_data_out[0 +: ACC_W]);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat;
    op = 2'd0; sgn = 1'b0; a_data = 64'h05; b_data = 64'h05;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    ap_ce = 1'b0; ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0; ap_ce = 1'b1;
    checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b1 || ap_done !== 1'b0 ||
        c_data_out !== '0 || c_data_available_port !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: idle=%b ready=%b done=%b avail=%b c=%h required 1 1 0 0 0",
               ap_idle, ap_ready, ap_done, c_data_available_port, c_data_out);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ap_done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_busy_nodone: done pulses=%0d required 0", seen);
    end
    run_txn(2'd0, 1'b0, 64'h07, 64'h07, lat);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    checks++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1 || c_data_out !== '0) begin
      errors++;
      $display("FAIL rst_done: done=%b idle=%b c=%h required 0 1 0", ap_done, ap_idle, c_data_out);
    end
  endtask

  initial begin
    test_reset();
    test_mul_unsigned();
    test_mul_signed();
    test_mac_chain();
    test_overflow();
    test_handshake();
    test_ce_stall();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
